// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings
// (also used by the controller decode) and default latencies.
package mdu_pkg;

  localparam int MDU_WIDTH       = 32;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 4;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU. Produces the {hi,lo} result that
// the top level parks in its pending registers, plus a divide-by-zero flag.
// Signed division works on magnitudes so MIN/-1 falls out as quotient MIN,
// remainder 0 with no special casing.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  mdu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div0_o
);

  logic               is_signed;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign is_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign is_div    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
  assign a_neg     = is_signed & a_i[WIDTH-1];
  assign b_neg     = is_signed & b_i[WIDTH-1];

  // Sign- or zero-extend to 2W; the low 2W bits of the product are then
  // correct for both signed and unsigned multiplication.
  assign a_ext = is_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
  assign b_ext = is_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
  assign prod  = a_ext * b_ext;

  // Magnitude division; a zero divisor is replaced by 1 so the datapath
  // never sees an undefined divide, and the result is discarded at commit.
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign div0_o = is_div && (b_i == '0);
  assign b_safe = (b_i == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  assign hi_o = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
  assign lo_o = is_div ? quot : prod[WIDTH-1:0];

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue and held in pending registers; a down
// counter models the multi-cycle latency and HI/LO update on the edge the
// counter reaches zero. Starts while busy are ignored.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int CNT_W       = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_op_e          op;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             calc_div0;

  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             div0_q,   div0_d;
  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  assign op = mdu_op_e'(MDUOp);

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op_i   (op),
    .a_i    (Op1),
    .b_i    (Op2),
    .hi_o   (calc_hi),
    .lo_o   (calc_lo),
    .div0_o (calc_div0)
  );

  // Next-state: count down and commit while busy, otherwise accept a new op.
  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;

    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (!div0_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (start) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          div0_d    = 1'b0;
          cnt_d     = CNT_W'(MULT_CYCLES);
          busy_d    = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          div0_d    = calc_div0;
          cnt_d     = CNT_W'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        MDU_MTHI: hi_d = Op1;
        MDU_MTLO: lo_d = Op1;
        default:  ;
      endcase
    end
  end

  // State registers with synchronous reset that aborts any op in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases followed by random ops,
// compared against a plain-arithmetic HI/LO model.
module tb_mdu;

  localparam int W     = 32;
  localparam int MULTN = 5;
  localparam int DIVN  = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   MDUOp;
  logic [W-1:0] Op1;
  logic [W-1:0] Op2;
  logic         busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  mdu #(
    .WIDTH       (W),
    .MULT_CYCLES (MULTN),
    .DIV_CYCLES  (DIVN),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUOp (MDUOp),
    .Op1   (Op1),
    .Op2   (Op2),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {hi,lo} after the op commits, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] ch,
                                             input logic [W-1:0] cl);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; return p; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; return p; end
      3'd3: begin
        if (b == 0) return {ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {ch, cl};
        return {a % b, a / b};
      end
      3'd5: return {a, cl};
      3'd6: return {ch, a};
      default: return {ch, cl};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return MULTN;
      3'd3, 3'd4: return DIVN;
      default:    return 0;
    endcase
  endfunction

  // Called at a negedge; issues op for one cycle, checks busy/HI/LO through
  // commit and returns at the negedge of the first cycle with busy low.
  // With poke set, stray starts (mtlo, div) are driven in busy cycles 2 and 3.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    logic [63:0] nxt;
    int          n;
    nxt   = ref_result(op, a, b, m_hi, m_lo);
    n     = latency(op);
    start = 1'b1;
    MDUOp = op;
    Op1   = a;
    Op2   = b;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 3'd0;
    Op1   = $urandom;
    Op2   = $urandom;
    for (int k = 0; k < n; k++) begin
      check("busy_during", busy, 1);
      check("hi_hold", HI, m_hi);
      check("lo_hold", LO, m_lo);
      if (poke && (k == 1 || k == 2)) begin
        start = 1'b1;
        MDUOp = (k == 1) ? 3'd6 : 3'd3;
        Op1   = 32'h0000_AAAA;
        Op2   = 32'h0000_0003;
      end else begin
        start = 1'b0;
        MDUOp = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    MDUOp = 3'd0;
    m_hi  = nxt[63:32];
    m_lo  = nxt[31:0];
    check("busy_after", busy, 0);
    check("hi_after", HI, m_hi);
    check("lo_after", LO, m_lo);
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    int           sel;

    reset = 1'b1;
    start = 1'b0;
    MDUOp = 3'd0;
    Op1   = '0;
    Op2   = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);

    // Signed mult -2 * 3.
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi_lit", HI, 32'hFFFF_FFFF);
    check("mult_lo_lit", LO, 32'hFFFF_FFFA);

    // Unsigned max * max.
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_hi_lit", HI, 32'hFFFF_FFFE);
    check("multu_lo_lit", LO, 32'h0000_0001);

    // Signed div -7 / 2 and MIN / -1.
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_hi_lit", HI, 32'hFFFF_FFFF);
    check("div_lo_lit", LO, 32'hFFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("divovf_hi_lit", HI, 32'h0000_0000);
    check("divovf_lo_lit", LO, 32'h8000_0000);

    // mthi / mtlo back to back, then divu by zero leaves them intact.
    run_op(3'd5, 32'h0000_1234, 32'd0, 0);
    run_op(3'd6, 32'h0000_5678, 32'd0, 0);
    run_op(3'd4, 32'd99, 32'd0, 0);
    check("div0_hi_lit", HI, 32'h0000_1234);
    check("div0_lo_lit", LO, 32'h0000_5678);

    // Stray starts while busy are ignored; next op accepted immediately.
    run_op(3'd1, 32'd2, 32'd3, 1);
    check("poke_hi_lit", HI, 32'h0000_0000);
    check("poke_lo_lit", LO, 32'h0000_0006);
    run_op(3'd4, 32'd100, 32'd7, 0);
    check("b2b_lo_lit", LO, 32'd14);
    check("b2b_hi_lit", HI, 32'd2);

    // Reset in busy cycle 4 of div 100/7 aborts; no late commit.
    start = 1'b1;
    MDUOp = 3'd3;
    Op1   = 32'd100;
    Op2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 3'd0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    check("midrst_busy", busy, 0);
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    repeat (DIVN + 2) @(negedge clk);
    check("late_busy", busy, 0);
    check("late_hi", HI, 0);
    check("late_lo", LO, 0);

    // Random ops with biased corner operands.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 50)) - 32'd25; rb = 32'($urandom_range(1, 9)); end
      else if (sel == 3) rb = -32'($urandom_range(1, 9));
      run_op(rop, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
